// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_ctrl
// Purpose  : SPI command sequencer over a 4x8 register bank, with LED drive.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl #(
    parameter int         DIV_SHIFT = 16,
    parameter logic [3:0] STATUS_ID = 4'hA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       frame_end,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    output logic       led,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_WDATA = 3'd2,
        S_RDATA = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t     state, state_nx;
    logic [1:0] ptr, ptr_nx, ptr_inc;
    logic [7:0] reg0, reg1, reg2;
    logic [2:0] frame_cnt;
    logic [7:0] status;
    logic [7:0] rd_bank [4];
    logic [7:0] tx_nx;
    logic       load_nx;
    logic       wr_en;
    logic       err_set;
    logic       err_clr;
    logic       frame_inc;

    assign status  = {STATUS_ID, frame_cnt, err};
    assign ptr_inc = ptr + 2'd1;

    always_comb begin
        rd_bank[0] = reg0;
        rd_bank[1] = reg1;
        rd_bank[2] = reg2;
        rd_bank[3] = status;
    end

    // Received byte is handled first; frame_start/frame_end then override the state.
    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        tx_nx     = tx_byte;
        load_nx   = 1'b0;
        wr_en     = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        frame_inc = 1'b0;

        if (rx_valid) begin
            case (state)
                S_CMD: begin
                    if (rx_byte[6:2] != 5'd0) begin
                        state_nx = S_ERR;
                        err_set  = 1'b1;
                        tx_nx    = 8'hFF;
                        load_nx  = 1'b1;
                    end else begin
                        ptr_nx = rx_byte[1:0];
                        if (rx_byte[7]) begin
                            state_nx = S_WDATA;
                        end else begin
                            state_nx = S_RDATA;
                            tx_nx    = rd_bank[rx_byte[1:0]];
                            load_nx  = 1'b1;
                        end
                    end
                end
                S_WDATA: begin
                    wr_en   = 1'b1;
                    err_clr = (ptr == 2'd3) && rx_byte[0];
                    ptr_nx  = ptr_inc;
                end
                S_RDATA: begin
                    ptr_nx  = ptr_inc;
                    tx_nx   = rd_bank[ptr_inc];
                    load_nx = 1'b1;
                end
                default: ;
            endcase
        end

        if (frame_start) begin
            if (state != S_IDLE) begin
                err_set = 1'b1;
            end
            state_nx  = S_CMD;
            frame_inc = 1'b1;
            tx_nx     = {STATUS_ID, frame_cnt + 3'd1, err_set | (err & ~err_clr)};
            load_nx   = 1'b1;
        end else if (frame_end) begin
            state_nx = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 2'd0;
            tx_byte   <= 8'h00;
            tx_load   <= 1'b0;
            reg0      <= 8'h00;
            reg1      <= 8'h01;
            reg2      <= 8'h00;
            err       <= 1'b0;
            frame_cnt <= 3'd0;
        end else begin
            ptr     <= ptr_nx;
            tx_byte <= tx_nx;
            tx_load <= load_nx;
            if (wr_en) begin
                case (ptr)
                    2'd0:    reg0 <= rx_byte;
                    2'd1:    reg1 <= rx_byte;
                    2'd2:    reg2 <= rx_byte;
                    default: ;
                endcase
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 3'd1;
            end
        end
    end

    logic [DIV_SHIFT-1:0] presc;
    logic [7:0]           blink_cnt;
    logic [7:0]           half_m1;
    logic                 blink_en_q;
    logic                 tick;

    assign tick    = &presc;
    assign half_m1 = (reg1 == 8'd0) ? 8'd0 : reg1 - 8'd1;

    // Equality compare: a half-period lowered below the running count wraps through 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            blink_cnt  <= 8'd0;
            blink_en_q <= 1'b0;
            led        <= 1'b0;
        end else begin
            presc      <= presc + DIV_SHIFT'(1);
            blink_en_q <= reg0[1];
            if (!reg0[1]) begin
                led <= reg0[0];
            end else if (!blink_en_q) begin
                blink_cnt <= 8'd0;
                led       <= reg0[0];
            end else if (tick) begin
                if (blink_cnt == half_m1) begin
                    blink_cnt <= 8'd0;
                    led       <= ~led;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_ctrl
// Purpose  : Self-checking bench for spi_reg_ctrl against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       frame_end = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       led;
    logic       err;

    spi_reg_ctrl #(.DIV_SHIFT(2), .STATUS_ID(4'hA)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_byte(tx_byte), .tx_load(tx_load),
        .led(led), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level model of the register bank.
    logic [7:0] mregs [4];
    logic       merr;
    int         mcnt;
    logic       in_frame;

    logic [7:0] obs_tx;
    logic       obs_ld;
    logic [7:0] st_tx;
    logic       st_ld;
    logic [7:0] rd_tx [8];
    logic       rd_ld [8];
    logic [7:0] wbuf  [8];

    function automatic logic [7:0] m_status();
        return {4'hA, mcnt[2:0], merr};
    endfunction

    function automatic logic [7:0] m_read(input logic [1:0] a);
        if (a == 2'd3) return m_status();
        return mregs[a];
    endfunction

    function automatic void m_write(input logic [1:0] a, input logic [7:0] v);
        if (a == 2'd3) begin
            if (v[0]) merr = 1'b0;
        end else begin
            mregs[a] = v;
        end
    endfunction

    function automatic void m_reset();
        mregs[0] = 8'h00; mregs[1] = 8'h01; mregs[2] = 8'h00; mregs[3] = 8'h00;
        merr = 1'b0; mcnt = 0; in_frame = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        m_reset();
    endtask

    task automatic fstart();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        obs_tx = tx_byte; obs_ld = tx_load;
        if (in_frame) merr = 1'b1;
        in_frame = 1'b1;
        mcnt++;
    endtask

    task automatic sbyte(input logic [7:0] b);
        rx_valid = 1'b1; rx_byte = b; tick(); rx_valid = 1'b0;
        obs_tx = tx_byte; obs_ld = tx_load;
        tick();
    endtask

    task automatic fend();
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        in_frame = 1'b0;
        tick();
    endtask

    task automatic wr_frame(input logic [1:0] addr, input int n);
        logic [1:0] a;
        a = addr;
        fstart();
        sbyte({1'b1, 5'd0, addr});
        for (int i = 0; i < n; i++) begin
            sbyte(wbuf[i]);
            m_write(a, wbuf[i]);
            a = a + 2'd1;
        end
        fend();
    endtask

    task automatic rd_frame(input logic [1:0] addr, input int n);
        fstart();
        st_tx = obs_tx; st_ld = obs_ld;
        sbyte({1'b0, 5'd0, addr});
        rd_tx[0] = obs_tx; rd_ld[0] = obs_ld;
        for (int i = 1; i < n; i++) begin
            sbyte(8'($urandom));
            rd_tx[i] = obs_tx; rd_ld[i] = obs_ld;
        end
        fend();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx got=%h exp=00", tx_byte); end
        total++; if (tx_load !== 1'b0) begin bad++; $display("FAIL reset_load got=%b exp=0", tx_load); end
        total++; if (led !== 1'b0) begin bad++; $display("FAIL reset_led got=%b exp=0", led); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        rd_frame(2'd0, 3);
        total++; if (st_ld !== 1'b1 || st_tx !== m_status()) begin bad++; $display("FAIL reset_status ld=%b got=%h exp=%h", st_ld, st_tx, m_status()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (rd_tx[i] !== m_read(2'(i))) begin bad++; $display("FAIL reset_reg%0d got=%h exp=%h", i, rd_tx[i], m_read(2'(i))); end
        end
    endtask

    task automatic test_write_read();
        wbuf[0] = 8'h5A;
        wr_frame(2'd2, 1);
        rd_frame(2'd2, 1);
        total++; if (rd_ld[0] !== 1'b1) begin bad++; $display("FAIL wr_rd_load got=%b exp=1", rd_ld[0]); end
        total++; if (rd_tx[0] !== 8'h5A) begin bad++; $display("FAIL wr_rd_data got=%h exp=5a", rd_tx[0]); end
    endtask

    task automatic test_burst_wrap();
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        wr_frame(2'd2, 3);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL burst_err got=%b exp=0", err); end
        rd_frame(2'd0, 4);
        total++; if (rd_tx[0] !== 8'h33) begin bad++; $display("FAIL burst_reg0 got=%h exp=33", rd_tx[0]); end
        total++; if (rd_tx[1] !== 8'h01) begin bad++; $display("FAIL burst_reg1 got=%h exp=01", rd_tx[1]); end
        total++; if (rd_tx[2] !== 8'h11) begin bad++; $display("FAIL burst_reg2 got=%h exp=11", rd_tx[2]); end
        total++; if (rd_tx[3] !== m_status()) begin bad++; $display("FAIL burst_status got=%h exp=%h", rd_tx[3], m_status()); end
    endtask

    task automatic measure_blink(input string nm, input int period);
        int   last;
        int   ntog;
        logic prev;
        last = -1; ntog = 0; prev = led;
        for (int c = 0; c < 8 * period + 20; c++) begin
            tick();
            if (led !== prev) begin
                if (last >= 0) begin
                    total++; if (c - last != period) begin bad++; $display("FAIL %s_gap got=%0d exp=%0d", nm, c - last, period); end
                end
                last = c; prev = led; ntog++;
            end
        end
        total++; if (ntog < 4) begin bad++; $display("FAIL %s_toggles got=%0d exp>=4", nm, ntog); end
    endtask

    task automatic test_blink();
        wbuf[0] = 8'h00; wr_frame(2'd0, 1);
        total++; if (led !== 1'b0) begin bad++; $display("FAIL blink_off_led got=%b exp=0", led); end
        wbuf[0] = 8'h03; wr_frame(2'd1, 1);
        wbuf[0] = 8'h02; wr_frame(2'd0, 1);
        total++; if (led !== 1'b0) begin bad++; $display("FAIL blink_start_led got=%b exp=0", led); end
        measure_blink("blink3", 12);
        wbuf[0] = 8'h00; wr_frame(2'd0, 1);
        wbuf[0] = 8'h00; wr_frame(2'd1, 1);
        wbuf[0] = 8'h02; wr_frame(2'd0, 1);
        measure_blink("blink0", 4);
        wbuf[0] = 8'h01; wr_frame(2'd0, 1);
        total++; if (led !== 1'b1) begin bad++; $display("FAIL manual_led got=%b exp=1", led); end
    endtask

    task automatic test_bad_cmd();
        fstart();
        sbyte(8'h44);
        merr = 1'b1;
        total++; if (obs_ld !== 1'b1 || obs_tx !== 8'hFF) begin bad++; $display("FAIL badcmd_tx ld=%b got=%h exp=ff", obs_ld, obs_tx); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL badcmd_err got=%b exp=1", err); end
        sbyte(8'h12); sbyte(8'h34);
        total++; if (tx_byte !== 8'hFF) begin bad++; $display("FAIL badcmd_hold got=%h exp=ff", tx_byte); end
        fend();
        rd_frame(2'd0, 4);
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_tx[i] !== m_read(2'(i))) begin bad++; $display("FAIL badcmd_reg%0d got=%h exp=%h", i, rd_tx[i], m_read(2'(i))); end
        end
        wbuf[0] = 8'h01; wr_frame(2'd3, 1);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL errclr got=%b exp=0", err); end
    endtask

    task automatic test_frame_count();
        apply_reset();
        fstart(); fend();
        fstart(); fend();
        rd_frame(2'd3, 1);
        total++; if (rd_tx[0] !== 8'hA6) begin bad++; $display("FAIL fcnt3 got=%h exp=a6", rd_tx[0]); end
        for (int i = 0; i < 7; i++) begin fstart(); fend(); end
        rd_frame(2'd3, 1);
        total++; if (rd_tx[0] !== 8'hA6) begin bad++; $display("FAIL fcnt_wrap got=%h exp=a6", rd_tx[0]); end
    endtask

    task automatic test_end_coincident();
        fstart();
        sbyte(8'h82);
        rx_valid = 1'b1; rx_byte = 8'h77; frame_end = 1'b1;
        tick();
        rx_valid = 1'b0; frame_end = 1'b0; in_frame = 1'b0;
        m_write(2'd2, 8'h77);
        tick();
        rd_frame(2'd2, 1);
        total++; if (rd_tx[0] !== 8'h77) begin bad++; $display("FAIL end_coinc got=%h exp=77", rd_tx[0]); end
    endtask

    task automatic test_restart_wdata();
        fstart();
        sbyte(8'h80);
        fstart();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL restart_err got=%b exp=1", err); end
        total++; if (obs_ld !== 1'b1 || obs_tx !== m_status()) begin bad++; $display("FAIL restart_status ld=%b got=%h exp=%h", obs_ld, obs_tx, m_status()); end
        fend();
        wbuf[0] = 8'h01; wr_frame(2'd3, 1);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL restart_clr got=%b exp=0", err); end
    endtask

    task automatic test_rst_midframe();
        fstart();
        sbyte(8'h80);
        sbyte(8'h13);
        m_write(2'd0, 8'h13);
        total++; if (led !== 1'b1) begin bad++; $display("FAIL mid_led_pre got=%b exp=1", led); end
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        m_reset();
        total++; if (tx_byte !== 8'h00 || tx_load !== 1'b0) begin bad++; $display("FAIL mid_tx got=%h/%b exp=00/0", tx_byte, tx_load); end
        total++; if (led !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL mid_led_err got=%b/%b exp=0/0", led, err); end
        sbyte(8'h55); sbyte(8'h66);
        rd_frame(2'd0, 3);
        for (int i = 0; i < 3; i++) begin
            total++; if (rd_tx[i] !== m_read(2'(i))) begin bad++; $display("FAIL mid_reg%0d got=%h exp=%h", i, rd_tx[i], m_read(2'(i))); end
        end
    endtask

    task automatic test_random();
        logic [1:0] a;
        logic [7:0] b;
        int         n;
        for (int it = 0; it < 40; it++) begin
            a = 2'($urandom);
            n = int'($urandom_range(1, 5));
            case ($urandom_range(0, 3))
                0, 1: begin
                    for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                    wr_frame(a, n);
                end
                2: begin
                    rd_frame(a, n);
                    total++; if (st_ld !== 1'b1 || st_tx !== m_status()) begin bad++; $display("FAIL rnd_status ld=%b got=%h exp=%h", st_ld, st_tx, m_status()); end
                    for (int i = 0; i < n; i++) begin
                        total++; if (rd_ld[i] !== 1'b1 || rd_tx[i] !== m_read(a + 2'(i))) begin bad++; $display("FAIL rnd_read ld=%b got=%h exp=%h", rd_ld[i], rd_tx[i], m_read(a + 2'(i))); end
                    end
                end
                default: begin
                    b = 8'($urandom);
                    if (b[6:2] == 5'd0) b[4] = 1'b1;
                    fstart();
                    sbyte(b);
                    merr = 1'b1;
                    total++; if (obs_tx !== 8'hFF) begin bad++; $display("FAIL rnd_bad got=%h exp=ff", obs_tx); end
                    for (int i = 0; i < n; i++) sbyte(8'($urandom));
                    fend();
                end
            endcase
            total++; if (err !== merr) begin bad++; $display("FAIL rnd_err got=%b exp=%b", err, merr); end
            if (!mregs[0][1]) begin
                total++; if (led !== mregs[0][0]) begin bad++; $display("FAIL rnd_led got=%b exp=%b", led, mregs[0][0]); end
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_write_read();
        test_burst_wrap();
        test_blink();
        test_bad_cmd();
        test_frame_count();
        test_end_coincident();
        test_restart_wdata();
        test_rst_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command sequencer behind the SPI slave byte interface. Frames each SSEL-delimited transaction into a command byte plus data bytes.
- Reads and writes a 4-entry, 8-bit register bank and supplies the byte the slave shifts out on MISO.
- Drives the board LED from the register bank: manual level or hardware blink.
- Clocked from the internal oscillator domain, the same domain as the SPI slave.

Parameters:
- DIV_SHIFT, 16: prescaler width. One blink tick every 2^DIV_SHIFT clk cycles.
- STATUS_ID, 4'hA: constant placed in STATUS[7:4].

Ports:
- clk  in  1  oscillator clock
- rst  in  1  synchronous reset, active-high
- frame_start  in  1  one-cycle pulse; SSEL asserted (already synchronised)
- frame_end  in  1  one-cycle pulse; SSEL deasserted
- rx_valid  in  1  one-cycle pulse; rx_byte holds a completed received byte
- rx_byte  in  8  received byte
- tx_byte  out  8  byte for the slave to shift out on the next byte exchange
- tx_load  out  1  one-cycle pulse; slave latches tx_byte
- led  out  1  LED drive
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=1 at a clk edge):
  - outputs: tx_byte=8'h00, tx_load=0, led=0, err=0.
  - registers: reg0=8'h00, reg1=8'h01, reg2=8'h00.
  - prescaler=0, blink counter=0, frame count=0, state=IDLE.
  - Reset mid-frame aborts the frame; the next byte is treated as garbage until the next frame_start.
- Register map:
  - reg0 LED_CTRL: bit0 = manual level; bit1 = blink enable; bits[7:2] are stored and read back but unused.
  - reg1 BLINK_HALF: blink half-period in ticks. A value of 0 is treated as 1.
  - reg2 SCRATCH: read/write.
  - reg3 STATUS (read-only): {STATUS_ID, frame_cnt[2:0], err}. Writing with data bit0=1 clears err; all other written bits are ignored.
- Command byte:
  - bit7: 1=write, 0=read.
  - bits[6:2]: must be 0.
  - bits[1:0]: start address.
- State machine:
  - IDLE: frame_start -> CMD; increment frame_cnt (3 bits, wraps 7->0); tx_byte=STATUS; tx_load pulses the cycle after frame_start.
  - CMD, on rx_valid:
    - bits[6:2]!=0 -> ERR, set err.
    - write -> WDATA, ptr=addr.
    - read -> RDATA, ptr=addr; tx_byte=reg[addr]; tx_load the next cycle.
  - WDATA, on rx_valid: reg[ptr]<=rx_byte in that cycle; ptr<=ptr+1 (2-bit wrap, 3->0).
  - RDATA, on rx_valid (byte clocked out): ptr<=ptr+1; tx_byte=reg[ptr+1]; tx_load the next cycle.
  - ERR: ignore rx_valid; tx_byte=8'hFF.
  - Any state: frame_end -> IDLE, same cycle. A frame ending right after CMD is legal, with no write and no error.
- Read-data latency: tx_load asserts exactly 1 cycle after the triggering rx_valid or frame_start. tx_byte is stable from the tx_load cycle until the next load.
- Simultaneous events:
  - frame_end with rx_valid: the byte is processed first (a write commits), then state goes to IDLE.
  - frame_start while not IDLE: treated as frame_end followed by a new frame; err is set.
  - rx_valid in IDLE: ignored.
- LED:
  - Blink disabled: led=reg0 bit0, registered, 1-cycle delay after the write.
  - Blink enabled:
    - Tick when prescaler reaches all-ones.
    - Blink counter (8 bit) increments per tick. When it reaches max(reg1,1)-1 it clears and led toggles.
    - The 0->1 transition of the enable resets the counter and sets led=reg0 bit0.
  - Writing reg1 while blinking takes effect at the next compare; if the counter is already above the new value it counts up to 255 and wraps.

Test Plan:
- Write: frame with 8'h82, 8'h5A -> reg2=8'h5A. Read frame 8'h02 -> tx_byte=8'h5A with tx_load 1 cycle after the command rx_valid.
- Burst write with wrap: 8'h82, 11, 22, 33 -> reg2=8'h11; reg3 err-clear path gets 8'h22 (bit0=0, err unchanged); reg0=8'h33 (bit1=1 so blink on, bit0=1). Read of reg1 -> 8'h01.
- Blink: DIV_SHIFT=2, reg1=3, reg0=8'h02 -> led toggles every 12 clk cycles. reg1=0 -> toggles every 4 cycles.
- Bad command: byte 8'h44 -> err=1; following bytes change no register; tx_byte=8'hFF. Then write 8'h83, 8'h01 -> err=0.
- Frame count: 3 frames from reset -> STATUS=8'hA6 with err=0. 8 more frames -> frame_cnt wraps, STATUS=8'hA6 again.
- Edge cases:
  - rst asserted mid-write burst -> all outputs and registers return to reset values.
  - frame_end coincident with the data rx_valid -> the write commits.
  - frame_start while in WDATA -> err=1.
